time_set_controller: RTL and testbench
======================================

TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 30, meaning idle cycles in edit before auto-abort.
REQ-002 SHALL have parameter YEAR_MIN, default 2020, meaning lowest editable year.
REQ-003 SHALL have parameter YEAR_MAX, default 2025, meaning highest editable year.
REQ-004 SHALL have port clk, input, 1, the single clock (1 Hz tick domain of the clock block).
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports btn_mode, btn_next, btn_inc, btn_dec, input, 1 each, pre-debounced single-cycle pulses.
REQ-007 SHALL have ports cur_hour, cur_min, cur_sec, cur_day, cur_month, cur_year, input, 5/6/6/5/4/12, live time from the clock block.
REQ-008 SHALL have ports set_hour, set_min, set_sec, set_day, set_month, set_year, output, 5/6/6/5/4/12, shadow values driven to the clock block's set inputs.
REQ-009 SHALL have port load, output, 1, single-cycle pulse that drives the clock block's load/reset input.
REQ-010 SHALL have port editing, output, 1, high in any EDIT_* state.
REQ-011 SHALL have port field_sel, output, 3, 0=none, 1=hour, 2=min, 3=sec, 4=day, 5=month, 6=year.

Function
REQ-012 SHALL implement states IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC, EDIT_DAY, EDIT_MONTH, EDIT_YEAR, COMMIT.
REQ-013 SHALL, in IDLE on btn_mode, copy all cur_* into shadow registers and enter EDIT_HOUR on the next cycle.
REQ-014 SHALL, in EDIT_* on btn_next, advance hour->min->sec->day->month->year->COMMIT.
REQ-015 SHALL, in COMMIT, assert load for exactly one cycle with set_* stable, then return to IDLE.
REQ-016 SHALL, in EDIT_* on btn_mode, abort to IDLE without asserting load.
REQ-017 SHALL apply button priority btn_mode > btn_next > btn_inc/btn_dec; lower-priority buttons in the same cycle are ignored.
REQ-018 SHALL treat btn_inc and btn_dec asserted together as no change.
REQ-019 SHALL make every button effect visible on set_*/state one cycle after the pulse.
REQ-020 SHALL wrap hour 23<->0, min and sec 59<->0, month 12<->1, year YEAR_MAX<->YEAR_MIN on inc/dec.
REQ-021 SHALL wrap day between 1 and days_in_month(month, year) on inc/dec.
REQ-022 SHALL apply the leap rule (div 4 and not div 100) or div 400 -> February has 29 days.
REQ-023 SHALL clamp day to days_in_month in the same cycle that month or year changes (e.g. 31 Jan -> inc month -> 29 Feb 2024).
REQ-024 SHALL clamp out-of-range captured cur_* values (hour>23, min/sec>59, month 0 or >12, year outside bounds) to the nearest legal value at capture.
REQ-025 SHALL count cycles in EDIT_* with no button pulse, restart on any pulse, and abort to IDLE without load when count reaches TIMEOUT_CYCLES.
REQ-026 SHALL hold set_* at last shadow values in IDLE; load never asserts outside COMMIT.

Reset
REQ-027 SHALL, on reset, enter IDLE with set_* = 00:00:00, 1/1/YEAR_MIN, load=0, editing=0, field_sel=0, and the timeout counter cleared.
REQ-028 SHALL let reset mid-edit or in COMMIT discard the edit, with no load pulse in that or the following cycle.

Structure
REQ-029 SHALL place the state enum, field_sel codes, and YEAR_MIN/YEAR_MAX defaults in shared package time_pkg.
REQ-030 SHALL use one combinational sub-module month_len (month, year -> days) reused by the clock block.

Verification
REQ-031 SHALL cover: capture 10:20:30 5/3/2024, then mode, next x6 -> one load pulse with set_* = 10:20:30 5/3/2024.
REQ-032 SHALL cover: edit hour 23 and press inc -> 0; edit min 0 and press dec -> 59; edit year 2025 and press inc -> 2020.
REQ-033 SHALL cover: day 31, month 1, year 2023, then inc month -> day 28; at year 2024 -> day 29.
REQ-034 SHALL cover: enter edit, idle 30 cycles -> editing=0 and no load; same with a pulse at cycle 29 -> still editing at cycle 31.
REQ-035 SHALL cover: btn_mode and btn_inc asserted together in EDIT_MIN -> abort with min unchanged; btn_inc and btn_dec together -> no change.
REQ-036 SHALL cover: reset asserted in COMMIT -> load=0 and outputs at reset values next cycle.

Source files
------------

// File: rtl/time_pkg.sv
// Shared definitions for the time-set controller and the clock block.
package time_pkg;

  localparam int unsigned YearMinDefault = 2020;
  localparam int unsigned YearMaxDefault = 2025;

  typedef logic [2:0] state_t;

  // Edit states are encoded so that the state value doubles as the field_sel code
  // and btn_next is a plain increment (StEditYear + 1 == StCommit).
  localparam state_t StIdle      = 3'd0;
  localparam state_t StEditHour  = 3'd1;
  localparam state_t StEditMin   = 3'd2;
  localparam state_t StEditSec   = 3'd3;
  localparam state_t StEditDay   = 3'd4;
  localparam state_t StEditMonth = 3'd5;
  localparam state_t StEditYear  = 3'd6;
  localparam state_t StCommit    = 3'd7;

  localparam logic [2:0] FieldNone  = 3'd0;
  localparam logic [2:0] FieldHour  = 3'd1;
  localparam logic [2:0] FieldMin   = 3'd2;
  localparam logic [2:0] FieldSec   = 3'd3;
  localparam logic [2:0] FieldDay   = 3'd4;
  localparam logic [2:0] FieldMonth = 3'd5;
  localparam logic [2:0] FieldYear  = 3'd6;

  // Gregorian leap rule.
  function automatic logic is_leap(input logic [11:0] year);
    return ((year % 12'd4 == 12'd0) && (year % 12'd100 != 12'd0)) ||
           (year % 12'd400 == 12'd0);
  endfunction

endpackage

// File: rtl/month_len.sv
// Days in a given month/year; purely combinational, shared with the clock block.
module month_len
  import time_pkg::*;
(
  input  logic [3:0]  month_i,
  input  logic [11:0] year_i,
  output logic [4:0]  days_o
);

  // Month lookup with leap-aware February; illegal months fall back to 31.
  always_comb begin
    days_o = 5'd31;
    case (month_i)
      4'd2:                    days_o = is_leap(year_i) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: days_o = 5'd30;
      default:                 days_o = 5'd31;
    endcase
  end

endmodule

// File: rtl/time_set_controller.sv
// Shadow-register time editor: captures the live time, lets the user step through the
// fields with wrap- and leap-aware inc/dec, and pulses load to write the result back.
module time_set_controller
  import time_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 30,
  parameter int unsigned YEAR_MIN       = YearMinDefault,
  parameter int unsigned YEAR_MAX       = YearMaxDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [4:0]  cur_hour,
  input  logic [5:0]  cur_min,
  input  logic [5:0]  cur_sec,
  input  logic [4:0]  cur_day,
  input  logic [3:0]  cur_month,
  input  logic [11:0] cur_year,
  output logic [4:0]  set_hour,
  output logic [5:0]  set_min,
  output logic [5:0]  set_sec,
  output logic [4:0]  set_day,
  output logic [3:0]  set_month,
  output logic [11:0] set_year,
  output logic        load,
  output logic        editing,
  output logic [2:0]  field_sel
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [11:0]     YrMin   = 12'(YEAR_MIN);
  localparam logic [11:0]     YrMax   = 12'(YEAR_MAX);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      hour_q, hour_d, day_q, day_d;
  logic [5:0]      min_q, min_d, sec_q, sec_d;
  logic [3:0]      month_q, month_d, mon_nx, len_month, cap_month;
  logic [11:0]     year_q, year_d, yr_nx, len_year, cap_year;
  logic [4:0]      cap_hour, cap_day, dim;
  logic [5:0]      cap_min, cap_sec;
  logic            in_edit, capture, any_btn, step_up, step_dn;

  assign in_edit = (state_q != StIdle) && (state_q != StCommit);
  assign capture = (state_q == StIdle) && btn_mode;
  assign any_btn = btn_mode | btn_next | btn_inc | btn_dec;
  // inc/dec only act when no higher-priority button is present and they do not cancel.
  assign step_up = btn_inc & ~btn_dec & ~btn_mode & ~btn_next;
  assign step_dn = btn_dec & ~btn_inc & ~btn_mode & ~btn_next;

  // Clamp live values into legal range at capture time.
  always_comb begin
    cap_hour  = (cur_hour > 5'd23) ? 5'd23 : cur_hour;
    cap_min   = (cur_min > 6'd59) ? 6'd59 : cur_min;
    cap_sec   = (cur_sec > 6'd59) ? 6'd59 : cur_sec;
    cap_month = (cur_month == 4'd0) ? 4'd1 : (cur_month > 4'd12) ? 4'd12 : cur_month;
    cap_year  = (cur_year < YrMin) ? YrMin : (cur_year > YrMax) ? YrMax : cur_year;
    cap_day   = (cur_day == 5'd0) ? 5'd1 : (cur_day > dim) ? dim : cur_day;
  end

  // Month/year after this cycle's inc/dec, so day can be clamped against them at once.
  always_comb begin
    mon_nx = month_q;
    yr_nx  = year_q;
    if (state_q == StEditMonth) begin
      if (step_up)      mon_nx = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
      else if (step_dn) mon_nx = (month_q <= 4'd1) ? 4'd12 : month_q - 4'd1;
    end
    if (state_q == StEditYear) begin
      if (step_up)      yr_nx = (year_q >= YrMax) ? YrMin : year_q + 12'd1;
      else if (step_dn) yr_nx = (year_q <= YrMin) ? YrMax : year_q - 12'd1;
    end
  end

  assign len_month = capture ? cap_month : mon_nx;
  assign len_year  = capture ? cap_year : yr_nx;

  month_len u_month_len (
    .month_i (len_month),
    .year_i  (len_year),
    .days_o  (dim)
  );

  // State sequencing, idle timeout and shadow-field editing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    day_d   = day_q;
    month_d = month_q;
    year_d  = year_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (btn_mode) begin
          state_d = StEditHour;
          hour_d  = cap_hour;
          min_d   = cap_min;
          sec_d   = cap_sec;
          day_d   = cap_day;
          month_d = cap_month;
          year_d  = cap_year;
        end
      end
      StCommit: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        cnt_d = any_btn ? '0 : CntW'(cnt_q + 1'b1);
        if (btn_mode) begin
          state_d = StIdle;
        end else if (btn_next) begin
          state_d = state_q + 3'd1;
        end else if (!any_btn && cnt_q == CntLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
        case (state_q)
          StEditHour: begin
            if (step_up)      hour_d = (hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1;
            else if (step_dn) hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
          end
          StEditMin: begin
            if (step_up)      min_d = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
            else if (step_dn) min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
          end
          StEditSec: begin
            if (step_up)      sec_d = (sec_q >= 6'd59) ? 6'd0 : sec_q + 6'd1;
            else if (step_dn) sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
          end
          StEditDay: begin
            if (step_up)      day_d = (day_q >= dim) ? 5'd1 : day_q + 5'd1;
            else if (step_dn) day_d = (day_q <= 5'd1) ? dim : day_q - 5'd1;
          end
          default: ;
        endcase
        month_d = mon_nx;
        year_d  = yr_nx;
        if (state_q != StEditDay && day_q > dim) day_d = dim;
      end
    endcase
  end

  // Registered state and shadow values with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hour_q  <= 5'd0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      day_q   <= 5'd1;
      month_q <= 4'd1;
      year_q  <= YrMin;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
    end
  end

  assign set_hour  = hour_q;
  assign set_min   = min_q;
  assign set_sec   = sec_q;
  assign set_day   = day_q;
  assign set_month = month_q;
  assign set_year  = year_q;
  assign editing   = in_edit;
  assign field_sel = in_edit ? state_q : FieldNone;
  // Gated by reset so a reset landing on the COMMIT cycle suppresses the pulse.
  assign load      = (state_q == StCommit) & ~reset;

endmodule

// File: tb/tb_time_set_controller.sv
// Randomized and directed bench for time_set_controller against a behavioural model.
module tb_time_set_controller;

  localparam int Timeout = 30;
  localparam int YMin    = 2020;
  localparam int YMax    = 2025;

  logic        clk;
  logic        reset, btn_mode, btn_next, btn_inc, btn_dec;
  logic [4:0]  cur_hour, cur_day, set_hour, set_day;
  logic [5:0]  cur_min, cur_sec, set_min, set_sec;
  logic [3:0]  cur_month, set_month;
  logic [11:0] cur_year, set_year;
  logic        load, editing;
  logic [2:0]  field_sel;

  int n_checks = 0;
  int n_errors = 0;
  int load_count = 0;

  // Model: st 0 = idle, 1..6 = editing that field, 7 = commit.
  int m_st, m_h, m_mi, m_s, m_d, m_mo, m_y, m_idle;

  time_set_controller #(
    .TIMEOUT_CYCLES (Timeout),
    .YEAR_MIN       (YMin),
    .YEAR_MAX       (YMax)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_mode  (btn_mode),
    .btn_next  (btn_next),
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .cur_hour  (cur_hour),
    .cur_min   (cur_min),
    .cur_sec   (cur_sec),
    .cur_day   (cur_day),
    .cur_month (cur_month),
    .cur_year  (cur_year),
    .set_hour  (set_hour),
    .set_min   (set_min),
    .set_sec   (set_sec),
    .set_day   (set_day),
    .set_month (set_month),
    .set_year  (set_year),
    .load      (load),
    .editing   (editing),
    .field_sel (field_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int days_in(int mo, int y);
    if (mo == 2) return (((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0)) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  function automatic int wrap(int v, int lo, int hi, int delta);
    int n;
    n = v + delta;
    if (n > hi) return lo;
    if (n < lo) return hi;
    return n;
  endfunction

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_step(input bit r, input bit bm, input bit bn, input bit bi, input bit bd);
    int delta;
    if (r) begin
      m_st = 0; m_h = 0; m_mi = 0; m_s = 0; m_d = 1; m_mo = 1; m_y = YMin; m_idle = 0;
      return;
    end
    if (m_st == 0) begin
      if (bm) begin
        m_h  = clampi(int'(cur_hour), 0, 23);
        m_mi = clampi(int'(cur_min), 0, 59);
        m_s  = clampi(int'(cur_sec), 0, 59);
        m_mo = clampi(int'(cur_month), 1, 12);
        m_y  = clampi(int'(cur_year), YMin, YMax);
        m_d  = clampi(int'(cur_day), 1, days_in(m_mo, m_y));
        m_st = 1;
        m_idle = 0;
      end
    end else if (m_st == 7) begin
      m_st = 0;
    end else begin
      if (bm) m_st = 0;
      else if (bn) m_st = m_st + 1;
      else if (bi != bd) begin
        delta = bi ? 1 : -1;
        case (m_st)
          1: m_h  = wrap(m_h, 0, 23, delta);
          2: m_mi = wrap(m_mi, 0, 59, delta);
          3: m_s  = wrap(m_s, 0, 59, delta);
          4: m_d  = wrap(m_d, 1, days_in(m_mo, m_y), delta);
          5: begin
            m_mo = wrap(m_mo, 1, 12, delta);
            if (m_d > days_in(m_mo, m_y)) m_d = days_in(m_mo, m_y);
          end
          default: begin
            m_y = wrap(m_y, YMin, YMax, delta);
            if (m_d > days_in(m_mo, m_y)) m_d = days_in(m_mo, m_y);
          end
        endcase
      end
      if (bm || bn || bi || bd) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == Timeout) begin
          m_st = 0;
          m_idle = 0;
        end
      end
    end
  endtask

  task automatic check_outputs(input bit r);
    bit exp_edit;
    exp_edit = (m_st >= 1 && m_st <= 6);
    check_eq("set_hour", set_hour, m_h);
    check_eq("set_min", set_min, m_mi);
    check_eq("set_sec", set_sec, m_s);
    check_eq("set_day", set_day, m_d);
    check_eq("set_month", set_month, m_mo);
    check_eq("set_year", set_year, m_y);
    check_eq("editing", editing, exp_edit);
    check_eq("field_sel", field_sel, exp_edit ? m_st : 0);
    check_eq("load", load, (m_st == 7 && !r) ? 1 : 0);
    if (load === 1'b1) load_count++;
  endtask

  // Drive one cycle of inputs, check pre-edge outputs, clock, update the model.
  task automatic do_cycle(input bit r, input bit bm, input bit bn, input bit bi, input bit bd);
    reset = r; btn_mode = bm; btn_next = bn; btn_inc = bi; btn_dec = bd;
    #1;
    check_outputs(r);
    @(posedge clk);
    model_step(r, bm, bn, bi, bd);
    #1;
  endtask

  task automatic press(input bit bm, input bit bn, input bit bi, input bit bd);
    do_cycle(1'b0, bm, bn, bi, bd);
  endtask

  task automatic set_cur(input int h, input int mi, input int s, input int d, input int mo,
                         input int y);
    cur_hour = 5'(h); cur_min = 6'(mi); cur_sec = 6'(s);
    cur_day = 5'(d); cur_month = 4'(mo); cur_year = 12'(y);
  endtask

  initial begin
    reset = 1'b1; btn_mode = 0; btn_next = 0; btn_inc = 0; btn_dec = 0;
    set_cur(7, 7, 7, 7, 7, 2022);
    repeat (2) @(posedge clk);
    model_step(1'b1, 0, 0, 0, 0);
    #1;
    check_eq("rst_hour", set_hour, 0);
    check_eq("rst_min", set_min, 0);
    check_eq("rst_sec", set_sec, 0);
    check_eq("rst_day", set_day, 1);
    check_eq("rst_month", set_month, 1);
    check_eq("rst_year", set_year, YMin);
    check_eq("rst_editing", editing, 0);
    check_eq("rst_field", field_sel, 0);
    check_eq("rst_load", load, 0);

    // Full pass through all fields commits the captured time once.
    set_cur(10, 20, 30, 5, 3, 2024);
    load_count = 0;
    press(1, 0, 0, 0);
    check_eq("capture_field", field_sel, 1);
    repeat (6) press(0, 1, 0, 0);
    repeat (2) press(0, 0, 0, 0);
    check_eq("commit_loads", load_count, 1);
    check_eq("commit_hour", set_hour, 10);
    check_eq("commit_min", set_min, 20);
    check_eq("commit_sec", set_sec, 30);
    check_eq("commit_day", set_day, 5);
    check_eq("commit_month", set_month, 3);
    check_eq("commit_year", set_year, 2024);

    // Wrap points.
    set_cur(23, 0, 45, 10, 6, 2025);
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    check_eq("hour_wrap_up", set_hour, 0);
    press(0, 1, 0, 0);
    press(0, 0, 0, 1);
    check_eq("min_wrap_dn", set_min, 59);
    repeat (4) press(0, 1, 0, 0);
    check_eq("at_year_field", field_sel, 6);
    press(0, 0, 1, 0);
    check_eq("year_wrap_up", set_year, YMin);
    press(1, 0, 0, 0);

    // Day clamps when month changes, leap-aware.
    set_cur(12, 0, 0, 31, 1, 2023);
    press(1, 0, 0, 0);
    repeat (4) press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    check_eq("clamp_month", set_month, 2);
    check_eq("clamp_day_2023", set_day, 28);
    press(1, 0, 0, 0);
    set_cur(12, 0, 0, 31, 1, 2024);
    press(1, 0, 0, 0);
    repeat (4) press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    check_eq("clamp_day_2024", set_day, 29);
    press(1, 0, 0, 0);

    // Idle timeout, and restart of the count by a late pulse.
    load_count = 0;
    press(1, 0, 0, 0);
    repeat (29) press(0, 0, 0, 0);
    check_eq("timeout_29", editing, 1);
    press(0, 0, 0, 0);
    check_eq("timeout_30", editing, 0);
    check_eq("timeout_no_load", load_count, 0);
    press(1, 0, 0, 0);
    repeat (28) press(0, 0, 0, 0);
    press(0, 0, 1, 0);
    repeat (2) press(0, 0, 0, 0);
    check_eq("timeout_restart", editing, 1);
    press(1, 0, 0, 0);

    // Priority and cancelling inc/dec.
    set_cur(8, 15, 0, 1, 1, 2021);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(1, 0, 1, 0);
    check_eq("prio_abort", editing, 0);
    check_eq("prio_min", set_min, 15);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(0, 0, 1, 1);
    check_eq("incdec_min", set_min, 15);
    check_eq("incdec_field", field_sel, 2);
    press(1, 0, 0, 0);

    // Reset during COMMIT.
    set_cur(10, 20, 30, 5, 3, 2024);
    load_count = 0;
    press(1, 0, 0, 0);
    repeat (6) press(0, 1, 0, 0);
    do_cycle(1'b1, 0, 0, 0, 0);
    check_eq("rc_hour", set_hour, 0);
    check_eq("rc_day", set_day, 1);
    check_eq("rc_year", set_year, YMin);
    check_eq("rc_editing", editing, 0);
    press(0, 0, 0, 0);
    check_eq("rc_no_load", load_count, 0);

    // Random traffic with out-of-range live values and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 499) repeat (35) press(0, 0, 0, 0);
      cur_hour = 5'($urandom_range(0, 31));
      cur_min = 6'($urandom_range(0, 63));
      cur_sec = 6'($urandom_range(0, 63));
      cur_day = 5'($urandom_range(0, 31));
      cur_month = 4'($urandom_range(0, 15));
      cur_year = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(2016, 2029));
      do_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
